// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store byte sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef logic [2:0] state_e;

    localparam state_e IDLE  = 3'd0;
    localparam state_e WRITE = 3'd1;
    localparam state_e READ  = 3'd2;
    localparam state_e DRAIN = 3'd3;
    localparam state_e RESP  = 3'd4;

    // Size code 2'b11 is handled as a word.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        case (size)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the assembled load bytes to the full core width.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] assy_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic fill_b;
    logic fill_h;

    assign fill_b = ~unsigned_i & assy_i[7];
    assign fill_h = ~unsigned_i & assy_i[15];

    always_comb begin
        data_o = assy_i;
        case (size_i)
            BYTE:    data_o = {{(XLEN-8){fill_b}}, assy_i[7:0]};
            HALF:    data_o = {{(XLEN-16){fill_h}}, assy_i[15:0]};
            default: data_o = assy_i;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Splits one core load/store into little-endian byte accesses on DMEM.
// Build option LSU_MISALIGN_EN: misaligned requests are carried out instead of rejected.
//
// state | meaning
// IDLE  | ready for a request; DMEM address held
// WRITE | store byte k on the port with write enable
// READ  | load address k on the port; byte k-1 returns this cycle
// DRAIN | last load byte returns; result extended
// RESP  | one-cycle response pulse
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 11,
    parameter int BYTE_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_misalign_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BYTE_W-1:0] mem_st_data_o,
    output logic              mem_st_en_o,
    input  logic [BYTE_W-1:0] mem_ld_data_i
);

    state_e            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   assy_q, assy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0] mem_st_data_q, mem_st_data_d;
    logic              mem_st_en_q, mem_st_en_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_misalign_q, rsp_misalign_d;

    logic              accept;
    logic              reject;
    logic [1:0]        last_k;
    logic [1:0]        k_nx;
    logic [1:0]        k_prev;
    logic [XLEN-1:0]   assy_fin;
    logic [XLEN-1:0]   ext_data;

    assign accept = req_valid_i && (state_q == IDLE);
    assign last_k = 2'(size_to_count(size_q) - 3'd1);
    assign k_nx   = k_q + 2'd1;
    assign k_prev = k_q - 2'd1;

`ifdef LSU_MISALIGN_EN
    assign reject = 1'b0;
`else
    assign reject = is_misaligned(req_size_i, req_addr_i[1:0]);
`endif

    // Assembly register with the byte arriving in DRAIN already merged in.
    always_comb begin
        assy_fin = assy_q;
        assy_fin[{k_q, 3'b000} +: BYTE_W] = mem_ld_data_i;
    end

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .assy_i     (assy_fin),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        we_d           = we_q;
        size_d         = size_q;
        uns_d          = uns_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        assy_d         = assy_q;
        mem_addr_d     = mem_addr_q;
        mem_st_data_d  = mem_st_data_q;
        mem_st_en_d    = 1'b0;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_misalign_d = rsp_misalign_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    k_d     = 2'd0;
                    assy_d  = '0;
                    if (reject) begin
                        state_d        = RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_rdata_d    = '0;
                        rsp_misalign_d = 1'b1;
                    end else begin
                        state_d     = req_we_i ? WRITE : READ;
                        mem_addr_d  = req_addr_i;
                        mem_st_en_d = req_we_i;
                        if (req_we_i) begin
                            mem_st_data_d = req_wdata_i[BYTE_W-1:0];
                        end
                    end
                end
            end
            WRITE: begin
                if (k_q == last_k) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_rdata_d    = '0;
                    rsp_misalign_d = 1'b0;
                end else begin
                    k_d           = k_nx;
                    mem_addr_d    = addr_q + ADDR_W'(k_nx);
                    mem_st_data_d = wdata_q[{k_nx, 3'b000} +: BYTE_W];
                    mem_st_en_d   = 1'b1;
                end
            end
            READ: begin
                // DMEM data lags the address by one cycle, so byte k-1 lands now.
                if (k_q != 2'd0) begin
                    assy_d[{k_prev, 3'b000} +: BYTE_W] = mem_ld_data_i;
                end
                if (k_q == last_k) begin
                    state_d = DRAIN;
                end else begin
                    k_d        = k_nx;
                    mem_addr_d = addr_q + ADDR_W'(k_nx);
                end
            end
            DRAIN: begin
                assy_d         = assy_fin;
                state_d        = RESP;
                rsp_valid_d    = 1'b1;
                rsp_rdata_d    = ext_data;
                rsp_misalign_d = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            k_q            <= '0;
            we_q           <= 1'b0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            assy_q         <= '0;
            mem_addr_q     <= '0;
            mem_st_data_q  <= '0;
            mem_st_en_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            we_q           <= we_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            assy_q         <= assy_d;
            mem_addr_q     <= mem_addr_d;
            mem_st_data_q  <= mem_st_data_d;
            mem_st_en_q    <= mem_st_en_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_misalign_q <= rsp_misalign_d;
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_misalign_o = rsp_misalign_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_st_data_o  = mem_st_data_q;
    assign mem_st_en_o    = mem_st_en_q;

    // we_q is kept for debug visibility of the in-flight request type.
    logic unused_we;
    assign unused_we = we_q;

endmodule
